cache_miss_ctrl: RTL
====================

Name: cache_miss_ctrl

Overview:
Sequences the memory side of a cache miss for the 2-way set-associative cache: optional write-back of a dirty victim, then refill read of the missing address from the 32x8 RAM.
- Sits between the cache core and the RAM and drives the packed 14-bit RAM request bus.
- Returns the fill byte with a one-cycle done pulse.
- Keeps saturating write-back and fill statistics.

Parameters:
ADDR_W, 5, address/tag width (RAM word address)
DATA_W, 8, data width
RAM_RD_LAT, 1, cycles from RAM address capture edge to valid qRAM (legal 1..4)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  miss request; sampled only while busy=0
req_addr  in  ADDR_W  address to fill
wb_en  in  1  victim dirty, write-back required
wb_addr  in  ADDR_W  victim tag (RAM address for write-back)
wb_data  in  DATA_W  victim data
stats_clr  in  1  synchronous clear of statistics counters
RAM  out  ADDR_W+1+DATA_W  packed RAM bus: [13:9] address, [8] wren, [7:0] write data
qRAM  in  DATA_W  RAM read data
busy  out  1  request in progress
done  out  1  one-cycle pulse, fill_data valid
fill_data  out  DATA_W  byte read from RAM, held until next done
wb_count  out  8  saturating count of write-backs issued
fill_count  out  8  saturating count of completed fills

Behaviour:
- Reset (async, any time): state IDLE, RAM=0, busy=0, done=0, fill_data=0, wb_count=0, fill_count=0, latched request cleared. An aborted request produces no done. A write-back interrupted in its WB cycle may or may not reach the RAM.
- All outputs are registered.
- States:
  - IDLE: on edge with req=1, latch req_addr/wb_en/wb_addr/wb_data and set busy<=1. Next state is WB if wb_en=1, else RD. The RAM bus is loaded at the same edge: in WB it is {wb_addr,1,wb_data}; in RD it is {req_addr,0,0}.
  - WB: exactly one cycle with wren=1. At the next edge: RAM<={req_addr,0,0}, rd_cnt<=0, wb_count++, go RD.
  - RD: wren=0, address held stable. rd_cnt increments each edge. At the edge where rd_cnt==RAM_RD_LAT: fill_data<=qRAM, done<=1, busy<=0, fill_count++, RAM<=0, go IDLE.
- done is low in every cycle except the one following completion.
- Latency, with E0 the accept edge:
  - no write-back: done high after edge E0+RAM_RD_LAT+1;
  - with write-back: after edge E0+RAM_RD_LAT+2.
- Back-to-back: req accepted at the edge right after the done edge, since the state is already IDLE.
- req while busy=1: ignored, not queued; latched values unchanged.
- wb_addr==req_addr: allowed. The read is issued after the write, so fill_data equals wb_data.
- Counters saturate at 255, no wrap. stats_clr has priority over a simultaneous increment, giving 0 that cycle.
- rd_cnt width is 3 bits. A RAM_RD_LAT outside 1..4 is flagged by an elaboration-time check.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W and DATA_W;
  - RAM bus field positions (RAM_ADDR_HI=13, RAM_ADDR_LO=9, RAM_WREN=8, RAM_DATA_HI=7);
  - state encoding localparams S_IDLE=2'd0, S_WB=2'd1, S_RD=2'd2.
- One sub-module, sat_counter (8-bit, inc/clr, async reset, saturates at 255), instantiated for wb_count and fill_count.

Test Plan:
1. Clean fill, RAM_RD_LAT=1, RAM[20]=8'h06: req=1, req_addr=20, wb_en=0 at E0 -> RAM=={5'd20,0,8'h00} from E0; done=1 exactly one cycle after E2; fill_data=8'h06; fill_count=1; wb_count=0.
2. Dirty victim: wb_en=1, wb_addr=22, wb_data=8'hA5, req_addr=4 (RAM[4]=8'h04) -> one cycle RAM=={22,1,8'hA5}; done after E3; RAM[22]==8'hA5; fill_data=8'h04; both counters=1.
3. Same address: wb_addr=req_addr=10, wb_data=8'h3C -> fill_data=8'h3C.
4. req held high during busy with changing req_addr -> the second request is accepted only at the edge after done. The first fill uses the original address.
5. Assert reset during WB and during RD -> all outputs 0 immediately (asynchronously); no done pulse; the next req completes normally.
6. Stats: 256 fills -> fill_count=255 (saturated). stats_clr coincident with done -> fill_count=0. Repeat with RAM_RD_LAT=3 -> done exactly 2 cycles later than in scenario 1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss controller.
//
// Holds the address/data widths, the field layout of the packed RAM request bus, the
// controller state encoding and a helper that packs one RAM request.
//
// RAM bus layout (RAM_W = 14 bits):
//   [13:9] word address
//   [8]    write enable
//   [7:0]  write data
package cache_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RAM_W  = ADDR_W + 1 + DATA_W;

    localparam int unsigned RAM_ADDR_HI = 13;
    localparam int unsigned RAM_ADDR_LO = 9;
    localparam int unsigned RAM_WREN    = 8;
    localparam int unsigned RAM_DATA_HI = 7;

    // Statistics counters and the read-latency counter.
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RD_CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StWb   = S_WB,
        StRd   = S_RD
    } state_e;

    // Build one RAM bus word from its fields.
    function automatic logic [RAM_W-1:0] ram_pack(
        input logic [ADDR_W-1:0] addr,
        input logic              wren,
        input logic [DATA_W-1:0] data
    );
        logic [RAM_W-1:0] bus;
        bus                            = '0;
        bus[RAM_ADDR_HI:RAM_ADDR_LO]   = addr;
        bus[RAM_WREN]                  = wren;
        bus[RAM_DATA_HI:0]             = data;
        return bus;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter.
//
// Counts up by one on each edge with inc=1 and sticks at its maximum value.
// A synchronous clear wins over a simultaneous increment.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset (count returns to 0)
//   inc    count one event this cycle
//   clr    synchronous clear
//   count  current count value
module sat_counter
    import cache_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CntMax)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Memory-side sequencer for a cache miss.
//
// Accepts one miss at a time. If the victim line is dirty it first issues a single write
// cycle to the RAM, then it issues the refill read of the missing address, waits for the
// RAM read latency, returns the byte on fill_data and pulses done for one cycle.
// Write-backs and completed fills are tallied in saturating counters.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   req        miss request, sampled only while idle
//   req_addr   address to refill
//   wb_en      victim is dirty, write it back first
//   wb_addr    victim RAM address
//   wb_data    victim data
//   stats_clr  synchronous clear of both statistics counters
//   RAM        packed RAM request bus {addr, wren, wdata}
//   qRAM       RAM read data
//   busy       a miss is being serviced
//   done       one-cycle pulse, fill_data is valid
//   fill_data  byte returned by the refill read, held until the next done
//   wb_count   saturating count of write-backs issued
//   fill_count saturating count of completed fills
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stats_clr,
    output logic [RAM_W-1:0]  RAM,
    input  logic [DATA_W-1:0] qRAM,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] fill_data,
    output logic [CNT_W-1:0]  wb_count,
    output logic [CNT_W-1:0]  fill_count
);

    if ((RAM_RD_LAT < 1) || (RAM_RD_LAT > 4)) begin : g_lat_check
        $error("cache_miss_ctrl: RAM_RD_LAT must be within 1..4");
    end

    localparam logic [RD_CNT_W-1:0] RdLast = RD_CNT_W'(RAM_RD_LAT);

    state_e              state_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [RD_CNT_W-1:0] rd_cnt_q;

    // The victim address/data go straight onto the RAM bus at accept time, so only the
    // refill address has to be kept for later cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            rd_cnt_q   <= '0;
            RAM        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fill_data  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        req_addr_q <= req_addr;
                        rd_cnt_q   <= '0;
                        busy       <= 1'b1;
                        if (wb_en) begin
                            state_q <= StWb;
                            RAM     <= ram_pack(wb_addr, 1'b1, wb_data);
                        end else begin
                            state_q <= StRd;
                            RAM     <= ram_pack(req_addr, 1'b0, '0);
                        end
                    end
                end
                StWb: begin
                    // Exactly one write cycle, then switch the bus to the refill read.
                    state_q  <= StRd;
                    rd_cnt_q <= '0;
                    RAM      <= ram_pack(req_addr_q, 1'b0, '0);
                end
                StRd: begin
                    // rd_cnt counts edges since the read address was put on the bus; the
                    // first of them is the RAM capture edge, hence completion at RdLast.
                    if (rd_cnt_q == RdLast) begin
                        state_q   <= StIdle;
                        fill_data <= qRAM;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        RAM       <= '0;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    RAM     <= '0;
                end
            endcase
        end
    end

    logic wb_inc;
    logic fill_inc;

    assign wb_inc   = (state_q == StWb);
    assign fill_inc = (state_q == StRd) && (rd_cnt_q == RdLast);

    sat_counter u_wb_count (
        .clock (clock),
        .reset (reset),
        .inc   (wb_inc),
        .clr   (stats_clr),
        .count (wb_count)
    );

    sat_counter u_fill_count (
        .clock (clock),
        .reset (reset),
        .inc   (fill_inc),
        .clr   (stats_clr),
        .count (fill_count)
    );

endmodule
